// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared types for the hazard unit: forwarding selects and the
//               memory wait-state FSM encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    // Operand source select for the Execute-stage ALU inputs
    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_W   = 2'b01,
        FWD_M   = 2'b10
    } fwd_t;

    // Wait-state FSM: normal flow, or frozen waiting on data memory
    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_t;

    // Register x0 is hard-wired to zero and is never a hazard source
    localparam logic [4:0] c_REG_ZERO = 5'd0;

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/hazard_forward.sv
`default_nettype none
// ============================================================================
// Module      : hazard_forward
// Description : Per-operand forwarding select. The Memory stage result is the
//               youngest, so it beats the Writeback stage; x0 never forwards.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_forward
    import hazard_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rd_m,
    input  logic [4:0] rd_w,
    input  logic       reg_write_m,
    input  logic       reg_write_w,
    output fwd_t       fwd
);

    // Pick the youngest in-flight producer of this source register
    always_comb begin
        fwd = FWD_REG;
        if (reg_write_m && (rd_m != c_REG_ZERO) && (rd_m == rs)) begin
            fwd = FWD_M;
        end else if (reg_write_w && (rd_w != c_REG_ZERO) && (rd_w == rs)) begin
            fwd = FWD_W;
        end
    end

endmodule : hazard_forward
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_unit
// Description : Pipeline hazard control: forwarding selects, load-use stall,
//               branch redirect flush, and a wait-state FSM that freezes the
//               whole pipe while data memory is busy, with a sticky watchdog.
//               Optional build macro HAZARD_PERF_EN adds saturating
//               performance counters for stalls and flushes.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_WIDTH   = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       MemReadE,
    input  logic       PCTakenE,
    input  logic       MemReqM,
    input  logic       MemReadyM,
    output fwd_t       ForwardAE,
    output fwd_t       ForwardBE,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       StallM,
    output logic       FlushD,
    output logic       FlushE,
    output logic       mem_timeout
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_WIDTH-1:0] perf_lu_stalls,
    output logic [CNT_WIDTH-1:0] perf_mem_stalls,
    output logic [CNT_WIDTH-1:0] perf_flushes
`endif
);

    // Watchdog value at which the current wait cycle is the last one allowed
    localparam logic [CNT_WIDTH-1:0] c_WD_LIMIT = CNT_WIDTH'(MEM_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX  = {CNT_WIDTH{1'b1}};

    hz_state_t              r_state;
    hz_state_t              w_state_next;
    logic [CNT_WIDTH-1:0]   r_watchdog;
    logic                   r_mem_timeout;
    logic                   w_mem_wait;
    logic                   w_load_use;
    fwd_t                   w_fwd_a;
    fwd_t                   w_fwd_b;

    hazard_forward u_fwd_a (
        .rs          (Rs1E),
        .rd_m        (RdM),
        .rd_w        (RdW),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .fwd         (w_fwd_a)
    );

    hazard_forward u_fwd_b (
        .rs          (Rs2E),
        .rd_m        (RdM),
        .rd_w        (RdW),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .fwd         (w_fwd_b)
    );

    // A wait is visible combinationally in the very cycle the request misses,
    // and ends in the same cycle MemReadyM arrives.
    assign w_mem_wait = ((r_state == RUN) && MemReqM && !MemReadyM) ||
                        ((r_state == MEM_WAIT) && !MemReadyM);

    assign w_load_use = MemReadE && (RdE != c_REG_ZERO) &&
                        ((RdE == Rs1D) || (RdE == Rs2D));

    // Wait-state FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic for the memory wait FSM
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RUN:      if (MemReqM && !MemReadyM) w_state_next = MEM_WAIT;
            MEM_WAIT: if (MemReadyM)             w_state_next = RUN;
            default:                             w_state_next = RUN;
        endcase
    end

    // Stall/flush priority: reset > memory wait > redirect > load-use
    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        ForwardAE = w_fwd_a;
        ForwardBE = w_fwd_b;
        if (rst) begin
            FlushD    = 1'b1;
            FlushE    = 1'b1;
            ForwardAE = FWD_REG;
            ForwardBE = FWD_REG;
        end else if (w_mem_wait) begin
            // Whole pipe frozen; a redirect in E is kept and acted on later
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
        end else if (PCTakenE) begin
            // The instruction a load-use stall would hold in D is dead anyway
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (w_load_use) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

    // Watchdog on consecutive wait cycles; timeout flag is sticky until reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_watchdog    <= '0;
            r_mem_timeout <= 1'b0;
        end else if (r_state == RUN) begin
            if (MemReqM && !MemReadyM) begin
                r_watchdog <= '0;
            end
        end else if (!MemReadyM) begin
            if (r_watchdog != c_CNT_MAX) begin
                r_watchdog <= r_watchdog + 1'b1;
            end
            if (r_watchdog >= c_WD_LIMIT) begin
                r_mem_timeout <= 1'b1;
            end
        end
    end

    assign mem_timeout = r_mem_timeout;

`ifdef HAZARD_PERF_EN
    logic w_lu_evt;
    logic w_flush_evt;

    assign w_lu_evt    = !w_mem_wait && !PCTakenE && w_load_use;
    assign w_flush_evt = !w_mem_wait && PCTakenE;

    // Saturating event counters for stall and flush cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_lu_stalls  <= '0;
            perf_mem_stalls <= '0;
            perf_flushes    <= '0;
        end else begin
            if (w_lu_evt && (perf_lu_stalls != c_CNT_MAX)) begin
                perf_lu_stalls <= perf_lu_stalls + 1'b1;
            end
            if (w_mem_wait && (perf_mem_stalls != c_CNT_MAX)) begin
                perf_mem_stalls <= perf_mem_stalls + 1'b1;
            end
            if (w_flush_evt && (perf_flushes != c_CNT_MAX)) begin
                perf_flushes <= perf_flushes + 1'b1;
            end
        end
    end
`endif

endmodule : hazard_unit
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_unit
// Description : Scoreboard bench for hazard_unit (MEM_TIMEOUT=4). Expected
//               output vectors are queued as stimulus is applied and popped
//               and compared on the following falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_unit;
    import hazard_pkg::*;

    localparam int c_CNT_W = 32;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic RegWriteM, RegWriteW, MemReadE, PCTakenE, MemReqM, MemReadyM;
    fwd_t ForwardAE, ForwardBE;
    logic StallF, StallD, StallE, StallM, FlushD, FlushE, mem_timeout;
`ifdef HAZARD_PERF_EN
    logic [c_CNT_W-1:0] perf_lu_stalls, perf_mem_stalls, perf_flushes;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    string      q_tag[$];
    logic [10:0] q_exp[$];

    hazard_unit #(.MEM_TIMEOUT(4), .CNT_WIDTH(c_CNT_W)) u_dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemReadE(MemReadE), .PCTakenE(PCTakenE),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .mem_timeout(mem_timeout)
`ifdef HAZARD_PERF_EN
        ,
        .perf_lu_stalls(perf_lu_stalls),
        .perf_mem_stalls(perf_mem_stalls),
        .perf_flushes(perf_flushes)
`endif
    );

    always #5 clk = ~clk;

    // Single comparison point: counts and reports every check
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected vector {StallF,D,E,M, FlushD,E, ForwardAE, ForwardBE, mem_timeout}
    function automatic logic [10:0] ex(input logic [3:0] st, input logic [1:0] fl,
                                       input fwd_t a, input fwd_t b, input logic to);
        return {st, fl, a, b, to};
    endfunction

    // Queue the expectation for the current inputs, compare at negedge,
    // then advance to just after the next rising edge
    task automatic step(input string tag, input logic [10:0] e);
        string       t;
        logic [10:0] x;
        q_tag.push_back(tag);
        q_exp.push_back(e);
        @(negedge clk);
        t = q_tag.pop_front();
        x = q_exp.pop_front();
        check_eq(t, 32'({StallF, StallD, StallE, StallM, FlushD, FlushE,
                         ForwardAE, ForwardBE, mem_timeout}), 32'(x));
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
        RdE = 5'd0; RdM = 5'd0; RdW = 5'd0;
        RegWriteM = 1'b0; RegWriteW = 1'b0; MemReadE = 1'b0;
        PCTakenE = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clr_in();
        repeat (2) @(posedge clk);
        #1;

        // Reset: forwarding forced to register file, flushes asserted
        RdM = 5'd5; RegWriteM = 1'b1; Rs1E = 5'd5; Rs2E = 5'd5;
        step("rst_fwd_forced", ex(4'b0000, 2'b11, FWD_REG, FWD_REG, 1'b0));
        rst = 1'b0;

        // Forwarding
        RdW = 5'd5; RegWriteW = 1'b1;
        step("fwd_m_beats_w", ex(4'b0000, 2'b00, FWD_M, FWD_M, 1'b0));
        RdM = 5'd0;
        step("fwd_w_rdm_x0", ex(4'b0000, 2'b00, FWD_W, FWD_W, 1'b0));
        Rs2E = 5'd0;
        step("fwd_rs2_x0", ex(4'b0000, 2'b00, FWD_W, FWD_REG, 1'b0));
        RdM = 5'd5; RegWriteM = 1'b0; Rs2E = 5'd5;
        step("fwd_m_no_we", ex(4'b0000, 2'b00, FWD_W, FWD_W, 1'b0));
        RdM = 5'd6; RegWriteM = 1'b1; RdW = 5'd6; RegWriteW = 1'b0; Rs2E = 5'd6;
        step("fwd_mixed", ex(4'b0000, 2'b00, FWD_REG, FWD_M, 1'b0));
        RdW = 5'd0; RegWriteW = 1'b1; RdM = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
        step("fwd_x0_never", ex(4'b0000, 2'b00, FWD_REG, FWD_REG, 1'b0));
        clr_in();

        // Load-use
        MemReadE = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
        step("lu_stall", ex(4'b1100, 2'b01, FWD_REG, FWD_REG, 1'b0));
        clr_in();
        step("lu_bubble", ex(4'b0000, 2'b00, FWD_REG, FWD_REG, 1'b0));
        MemReadE = 1'b1; RdE = 5'd0; Rs1D = 5'd0;
        step("lu_x0", ex(4'b0000, 2'b00, FWD_REG, FWD_REG, 1'b0));
        MemReadE = 1'b1; RdE = 5'd9; Rs1D = 5'd9; PCTakenE = 1'b1;
        step("redir_beats_lu", ex(4'b0000, 2'b11, FWD_REG, FWD_REG, 1'b0));
        clr_in();
        PCTakenE = 1'b1;
        step("redir_only", ex(4'b0000, 2'b11, FWD_REG, FWD_REG, 1'b0));
        clr_in();

        // Memory wait: four cycles with MemReadyM low, redirect held back
        MemReqM = 1'b1;
        step("mw_c0", ex(4'b1111, 2'b00, FWD_REG, FWD_REG, 1'b0));
        PCTakenE = 1'b1;
        step("mw_c1_redir", ex(4'b1111, 2'b00, FWD_REG, FWD_REG, 1'b0));
        MemReadE = 1'b1; RdE = 5'd7; Rs1D = 5'd7;
        step("mw_c2_lu", ex(4'b1111, 2'b00, FWD_REG, FWD_REG, 1'b0));
        step("mw_c3", ex(4'b1111, 2'b00, FWD_REG, FWD_REG, 1'b0));
        MemReadyM = 1'b1; PCTakenE = 1'b0; MemReadE = 1'b0;
        step("mw_release", ex(4'b0000, 2'b00, FWD_REG, FWD_REG, 1'b0));
        MemReqM = 1'b0; MemReadyM = 1'b0; PCTakenE = 1'b1;
        step("mw_flush_after", ex(4'b0000, 2'b11, FWD_REG, FWD_REG, 1'b0));
        PCTakenE = 1'b0; MemReqM = 1'b1; MemReadyM = 1'b1;
        step("zero_wait", ex(4'b0000, 2'b00, FWD_REG, FWD_REG, 1'b0));
        MemReqM = 1'b0; MemReadyM = 1'b0;
        step("zero_wait_run", ex(4'b0000, 2'b00, FWD_REG, FWD_REG, 1'b0));

        // Watchdog: flag rises after the 4th MEM_WAIT cycle
        MemReqM = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step($sformatf("wd_c%0d", i), ex(4'b1111, 2'b00, FWD_REG, FWD_REG, 1'b0));
        end
        step("wd_timeout", ex(4'b1111, 2'b00, FWD_REG, FWD_REG, 1'b1));
        MemReadyM = 1'b1;
        step("wd_release", ex(4'b0000, 2'b00, FWD_REG, FWD_REG, 1'b1));
        MemReqM = 1'b0; MemReadyM = 1'b0;
        step("wd_sticky", ex(4'b0000, 2'b00, FWD_REG, FWD_REG, 1'b1));

        // Reset in the middle of a memory wait
        MemReqM = 1'b1;
        step("rw_c0", ex(4'b1111, 2'b00, FWD_REG, FWD_REG, 1'b1));
        step("rw_c1", ex(4'b1111, 2'b00, FWD_REG, FWD_REG, 1'b1));
        rst = 1'b1; RdM = 5'd3; RegWriteM = 1'b1; Rs1E = 5'd3;
        step("rw_rst0", ex(4'b0000, 2'b11, FWD_REG, FWD_REG, 1'b1));
        step("rw_rst1", ex(4'b0000, 2'b11, FWD_REG, FWD_REG, 1'b0));
        clr_in();
`ifdef HAZARD_PERF_EN
        check_eq("perf_lu_zero",  perf_lu_stalls,  32'd0);
        check_eq("perf_mem_zero", perf_mem_stalls, 32'd0);
        check_eq("perf_fl_zero",  perf_flushes,    32'd0);
`endif
        rst = 1'b0; PCTakenE = 1'b1;
        step("rw_back_in_run", ex(4'b0000, 2'b11, FWD_REG, FWD_REG, 1'b0));
        clr_in();
        step("rw_idle", ex(4'b0000, 2'b00, FWD_REG, FWD_REG, 1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_hazard_unit
`default_nettype wire
